// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states, parity-mode codes and width helper for the UART transmitter
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous request FIFO in front of the UART transmitter
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8
) (
  input  logic             i_Clock,
  input  logic             i_reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge i_Clock or negedge i_reset)
    if (!i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  // storage is left unreset so it can map onto plain registers or RAM
  always_ff @(posedge i_Clock)
    if (do_push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter; UART_TX_FIFO_EN adds a request FIFO and o_empty
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int TICK_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                 i_Clock,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 sample_tick,
  input  logic                 i_start,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic [1:0]           i_parity_mode,
  input  logic                 i_stop2,
  output logic                 o_ready,
  output logic                 o_TX_Active,
  output logic                 o_TX,
  output logic                 o_TX_Done
`ifdef UART_TX_FIFO_EN
  ,
  output logic                 o_empty
`endif
);
  localparam int TW = clog2(TICK_PER_BIT);
  localparam int BW = clog2(DATA_BITS);
  localparam int EW = DATA_BITS + 3;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  if (DATA_BITS < 5 || DATA_BITS > 9 || TICK_PER_BIT < 2 || TICK_PER_BIT > 64 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("uart_tx_cfg: parameter out of legal range");
  end
  state_t state;
  logic [TW-1:0] tick;
  logic [BW-1:0] bit_idx;
  logic stop_idx, stop2;
  logic [1:0] pmode;
  logic [DATA_BITS-1:0] shreg;
  logic [EW-1:0] req;
  logic load, bit_end, par_on, par_bit;
`ifdef UART_TX_FIFO_EN
  logic full;
  uart_tx_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_Clock (i_Clock),
    .i_reset (i_reset),
    .push    (i_start & ~full & i_enable),
    .wdata   ({i_stop2, i_parity_mode, i_data}),
    .pop     (load),
    .rdata   (req),
    .full    (full),
    .empty   (o_empty)
  );
  assign o_ready = ~full;
  assign load    = (state == IDLE) & ~o_empty & i_enable;
`else
  assign req     = {i_stop2, i_parity_mode, i_data};
  assign o_ready = (state == IDLE) & i_enable;
  assign load    = i_start & o_ready;
`endif
  assign bit_end = sample_tick & (tick == TICK_LAST);
  assign par_on  = (pmode == PAR_EVEN) | (pmode == PAR_ODD);
  assign par_bit = (pmode == PAR_ODD) ? ~^shreg : ^shreg;
  // frame sequencer: walks start/data/parity/stop bits and drives registered line outputs
  always_ff @(posedge i_Clock or negedge i_reset)
    if (!i_reset) begin
      state       <= IDLE;
      tick        <= '0;
      bit_idx     <= '0;
      stop_idx    <= 1'b0;
      stop2       <= 1'b0;
      pmode       <= PAR_NONE;
      shreg       <= '0;
      o_TX        <= 1'b1;
      o_TX_Active <= 1'b0;
      o_TX_Done   <= 1'b0;
    end else begin
      o_TX_Done <= 1'b0;
      if (i_enable) begin
        if (state != IDLE && sample_tick) tick <= bit_end ? '0 : tick + 1'b1;
        case (state)
          IDLE: if (load) begin
            state                 <= START;
            {stop2, pmode, shreg} <= req;
            o_TX                  <= 1'b0;
            o_TX_Active           <= 1'b1;
          end
          START: if (bit_end) begin
            state <= DATA;
            o_TX  <= shreg[0];
          end
          DATA: if (bit_end) begin
            if (bit_idx == BIT_LAST) begin
              state    <= par_on ? PARITY : STOP;
              o_TX     <= par_on ? par_bit : 1'b1;
              bit_idx  <= '0;
              stop_idx <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              o_TX    <= shreg[bit_idx + 1'b1];
            end
          end
          PARITY: if (bit_end) begin
            state    <= STOP;
            o_TX     <= 1'b1;
            stop_idx <= 1'b0;
          end
          STOP: if (bit_end) begin
            if (stop_idx == stop2) begin
              state       <= IDLE;
              stop_idx    <= 1'b0;
              o_TX_Active <= 1'b0;
              o_TX_Done   <= 1'b1;
            end else begin
              stop_idx <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed bench for uart_tx_cfg with a frame-level reference model
`timescale 1ns/1ps
module tb_uart_tx_cfg;
  localparam int DB = 8, TPB = 4, DEPTH = 4;
`ifdef UART_TX_FIFO_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b1, tick = 1'b0, start = 1'b0, stop2 = 1'b0;
  logic [DB-1:0] data = '0;
  logic [1:0] pm = 2'b00;
  logic ready, active, tx, done;
`ifdef UART_TX_FIFO_EN
  logic empty;
`endif
  int checks = 0, errors = 0;
  int ph = 0, div = 1, ticks_seen = 0, lows = 0;

  always #5 clk = ~clk;

  uart_tx_cfg #(.DATA_BITS(DB), .TICK_PER_BIT(TPB), .FIFO_DEPTH(DEPTH)) dut (
    .i_Clock       (clk),
    .i_reset       (rst_n),
    .i_enable      (en),
    .sample_tick   (tick),
    .i_start       (start),
    .i_data        (data),
    .i_parity_mode (pm),
    .i_stop2       (stop2),
    .o_ready       (ready),
    .o_TX_Active   (active),
    .o_TX          (tx),
    .o_TX_Done     (done)
`ifdef UART_TX_FIFO_EN
    ,
    .o_empty       (empty)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // whole-frame line pattern, index 0 = start bit; unused upper bits read as idle-high
  function automatic logic [15:0] frame_bits(input logic [DB-1:0] d, input logic [1:0] p,
                                             input logic s, output int len);
    logic [15:0] b;
    int ones;
    b = '1;
    ones = $countones(d);
    b[0] = 1'b0;
    for (int i = 0; i < DB; i++) b[1+i] = d[i];
    len = 1 + DB;
    if (p == 2'b01 || p == 2'b10) begin
      b[len] = (p == 2'b01) ? (ones % 2 == 1) : (ones % 2 == 0);
      len++;
    end
    len += s ? 2 : 1;
    return b;
  endfunction

  typedef struct {logic [DB-1:0] d; logic [1:0] p; logic s;} req_t;
  req_t q[$];
  logic m_busy = 1'b0, m_done = 1'b0;
  int m_cnt = 0, m_len = 0, m_sz = 0;
  logic [15:0] m_bits = '1;

  task automatic m_load(input req_t r);
    m_bits = frame_bits(r.d, r.p, r.s, m_len);
    m_cnt = 0;
    m_busy = 1'b1;
  endtask

  // reference model: a frame is m_len bits of TPB counted ticks each
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_cnt = 0;
      q.delete();
    end else begin
      m_done = 1'b0;
      if (en) begin
        m_sz = q.size();
        if (m_busy) begin
          if (tick) m_cnt++;
          if (m_cnt == m_len * TPB) begin
            m_busy = 1'b0;
            m_done = 1'b1;
          end
        end
`ifdef UART_TX_FIFO_EN
        else if (m_sz > 0) m_load(q.pop_front());
        if (start && m_sz < DEPTH) q.push_back('{data, pm, stop2});
`else
        else if (start) m_load('{data, pm, stop2});
`endif
      end
    end
  end

  // every-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    chk("tx", tx, (rst_n && m_busy) ? m_bits[m_cnt / TPB] : 1'b1);
    chk("active", active, rst_n && m_busy);
    chk("done", done, rst_n && m_done);
    if (rst_n) begin
`ifdef UART_TX_FIFO_EN
      chk("ready", ready, q.size() < DEPTH);
      chk("empty", empty, q.size() == 0);
`else
      chk("ready", ready, !m_busy && en);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    if (tick && en) ticks_seen++;
    #2;
    ph++;
    tick = (ph % div == 0);
    if (!tx) lows++;
  endtask

  task automatic frame(input logic [DB-1:0] d, input logic [1:0] p, input logic s, input bit scramble,
                       output int nt, output int nd, output logic pb, output logic [15:0] seq);
    data = d;
    pm = p;
    stop2 = s;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (LAT - 1) step();
    ticks_seen = 0;
    nd = 0;
    nt = -1;
    pb = 1'bx;
    seq = '1;
    for (int i = 0; i < 3000 && nt < 0; i++) begin
      step();
      if (scramble) begin
        data = DB'($urandom);
        pm = 2'($urandom);
      end
      if (ticks_seen % TPB == 1) seq[ticks_seen / TPB] = tx;
      if (ticks_seen == 9 * TPB + 1) pb = tx;
      if (done) begin
        nd++;
        nt = ticks_seen;
      end
    end
    if (nt < 0) chk("frame_timeout", 0, 1);
    repeat (6) begin
      step();
      if (done) nd++;
    end
  endtask

  task automatic wait_done(input string name);
    int i;
    i = 0;
    while (!done && i < 3000) begin
      step();
      i++;
    end
    if (!done) chk(name, 0, 1);
  endtask

  initial begin
    int nt, nd, len;
    logic pb;
    logic [15:0] seq, b;
    repeat (3) step();
    chk("reset_tx", tx, 1'b1);
    chk("reset_active", active, 1'b0);
    chk("reset_done", done, 1'b0);
    rst_n = 1'b1;
    step();
    chk("ready_after_reset", ready, 1'b1);
    b = frame_bits(8'hA5, 2'b01, 1'b0, len);
    chk("model_a5_bits", b[10:0], 11'b10101001010);
    chk("model_a5_len", len, 11);
    b = frame_bits(8'h07, 2'b10, 1'b0, len);
    chk("model_odd_par", b[9], 1'b0);
    b = frame_bits(8'h07, 2'b01, 1'b0, len);
    chk("model_even_par", b[9], 1'b1);
    // 0xA5 even parity, one stop bit
    div = 4;
    frame(8'hA5, 2'b01, 1'b0, 0, nt, nd, pb, seq);
    chk("a5_ticks", nt, 44);
    chk("a5_dones", nd, 1);
    chk("a5_seq", seq[10:0], 11'b10101001010);
    // parity polarity and no-parity length
    div = 3;
    frame(8'h07, 2'b10, 1'b0, 0, nt, nd, pb, seq);
    chk("odd_par_bit", pb, 1'b0);
    chk("odd_ticks", nt, 44);
    frame(8'h07, 2'b01, 1'b0, 0, nt, nd, pb, seq);
    chk("even_par_bit", pb, 1'b1);
    frame(8'h07, 2'b11, 1'b0, 0, nt, nd, pb, seq);
    chk("nopar_ticks", nt, 40);
    // two stop bits while inputs churn mid-frame
    div = 2;
    frame(8'h3C, 2'b00, 1'b1, 1, nt, nd, pb, seq);
    chk("stop2_ticks", nt, 44);
    chk("stop2_dones", nd, 1);
    chk("stop2_seq", seq[10:0], 11'b11001111000);
    // reset during data bit 3
    data = 8'hC3;
    pm = 2'b00;
    stop2 = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (LAT - 1) step();
    ticks_seen = 0;
    for (int i = 0; i < 200 && ticks_seen < 4 * TPB + 1; i++) step();
    chk("abort_in_data3", ticks_seen, 4 * TPB + 1);
    rst_n = 1'b0;
    #1;
    chk("abort_tx", tx, 1'b1);
    chk("abort_active", active, 1'b0);
    nd = 0;
    repeat (4) begin
      step();
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0);
    rst_n = 1'b1;
    step();
    frame(8'h96, 2'b10, 1'b0, 0, nt, nd, pb, seq);
    chk("post_abort_ticks", nt, 44);
    chk("post_abort_dones", nd, 1);
    // enable low for 10 ticks inside the start bit
    div = 1;
    data = 8'hFF;
    pm = 2'b00;
    stop2 = 1'b0;
    lows = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (LAT - 1) step();
    repeat (2) step();
    en = 1'b0;
    repeat (10) step();
    en = 1'b1;
    for (int i = 0; i < 50 && !tx; i++) step();
    chk("frozen_start_len", lows, 14);
    wait_done("frozen_done_timeout");
    repeat (3) step();
`ifndef UART_TX_FIFO_EN
    // start held high: ignored while busy, re-accepted in the one-clock idle gap
    div = 2;
    data = 8'h5A;
    start = 1'b1;
    step();
    wait_done("gap_done_timeout");
    step();
    start = 1'b0;
    chk("gap_restart_tx", tx, 1'b0);
    chk("gap_restart_active", active, 1'b1);
    wait_done("gap_done2_timeout");
    repeat (3) step();
`else
    // fill the FIFO: first entry drains at once, then it fills and the sixth push is dropped
    div = 1;
    for (int i = 0; i < 6; i++) begin
      data = DB'((i + 1) * 8'h11);
      pm = 2'b00;
      stop2 = 1'b0;
      start = 1'b1;
      step();
      if (i == 4) chk("fifo_full_ready", ready, 1'b0);
    end
    start = 1'b0;
    nd = 0;
    for (int i = 0; i < 2000 && nd < 5; i++) begin
      step();
      if (done) nd++;
    end
    chk("fifo_frames", nd, 5);
    chk("fifo_empty_end", empty, 1'b1);
    repeat (3) step();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
endmodule
